// File: rtl/scan_addr_gen.sv
// Column / scan-row / bit-plane address generator for chained HUB75 panels.
// Shifts one column per step, then waits for the display side to acknowledge the line.
module scan_addr_gen #(
  parameter int NUM_PANELS = 1,
  parameter int PANEL_COLS = 32,
  parameter int SCAN_ROWS  = 8,
  parameter int PLANES     = 8,
  localparam int MAXCOL    = NUM_PANELS * PANEL_COLS - 1,
  localparam int COL_W     = ($clog2(MAXCOL + 1) > 1) ? $clog2(MAXCOL + 1) : 1,
  localparam int ROW_W     = ($clog2(SCAN_ROWS) > 1) ? $clog2(SCAN_ROWS) : 1,
  localparam int PL_W      = ($clog2(PLANES) > 1) ? $clog2(PLANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic             dir,
  input  logic             line_ack,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [PL_W-1:0]  plane,
  output logic             col_last,
  output logic             line_done,
  output logic             frame_done,
  output logic             waiting
);

  typedef enum logic [0:0] {SHIFT = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(MAXCOL);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);
  localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(PLANES - 1);

  state_t           state_r, state_s;
  logic [COL_W-1:0] col_r, col_s;
  logic [ROW_W-1:0] row_r, row_s;
  logic [PL_W-1:0]  plane_r, plane_s;
  logic             dir_r, dir_s;
  logic             line_done_r, line_done_s;
  logic             frame_done_r, frame_done_s;
  logic             col_last_s;

  // End of line depends on the direction latched at line start, not the live dir input.
  assign col_last_s = (!dir_r && (col_r == COL_MAX)) || (dir_r && (col_r == {COL_W{1'b0}}));

  // Next-state and next-counter logic; clr behaves exactly like reset.
  always_comb begin
    state_s      = state_r;
    col_s        = col_r;
    row_s        = row_r;
    plane_s      = plane_r;
    dir_s        = dir_r;
    line_done_s  = 1'b0;
    frame_done_s = 1'b0;
    if (clr) begin
      state_s = SHIFT;
      dir_s   = dir;
      col_s   = dir ? COL_MAX : {COL_W{1'b0}};
      row_s   = {ROW_W{1'b0}};
      plane_s = {PL_W{1'b0}};
    end else begin
      case (state_r)
        SHIFT: begin
          if (step) begin
            if (col_last_s) begin
              state_s      = WAIT;
              line_done_s  = 1'b1;
              frame_done_s = (row_r == ROW_LAST) && (plane_r == PL_LAST);
            end else if (dir_r) begin
              col_s = col_r - COL_W'(1);
            end else begin
              col_s = col_r + COL_W'(1);
            end
          end else begin
            state_s = SHIFT;
          end
        end
        WAIT: begin
          if (line_ack) begin
            state_s = SHIFT;
            dir_s   = dir;
            col_s   = dir ? COL_MAX : {COL_W{1'b0}};
            if (row_r == ROW_LAST) begin
              row_s   = {ROW_W{1'b0}};
              plane_s = (plane_r == PL_LAST) ? {PL_W{1'b0}} : plane_r + PL_W'(1);
            end else begin
              row_s = row_r + ROW_W'(1);
            end
          end else begin
            state_s = WAIT;
          end
        end
        default: begin
          state_s = SHIFT;
        end
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= SHIFT;
      dir_r        <= dir;
      col_r        <= dir ? COL_MAX : {COL_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      plane_r      <= {PL_W{1'b0}};
      line_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      dir_r        <= dir_s;
      col_r        <= col_s;
      row_r        <= row_s;
      plane_r      <= plane_s;
      line_done_r  <= line_done_s;
      frame_done_r <= frame_done_s;
    end
  end

  assign col        = col_r;
  assign row        = row_r;
  assign plane      = plane_r;
  assign col_last   = col_last_s;
  assign line_done  = line_done_r;
  assign frame_done = frame_done_r;
  assign waiting    = (state_r == WAIT);

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed self-checking bench for scan_addr_gen: default 1x32 config and a 2-panel,
// 2-row, 2-plane config exercising frame_done and descending scan.
module tb_scan_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance: 32 columns, 8 rows, 8 planes
  logic       rst, clr, step, dir, line_ack;
  logic [4:0] col;
  logic [2:0] row, plane;
  logic       col_last, line_done, frame_done, waiting;

  // second instance: 64 columns, 2 rows, 2 planes
  logic       rst2, clr2, step2, dir2, ack2;
  logic [5:0] col2;
  logic [0:0] row2, plane2;
  logic       col_last2, line_done2, frame_done2, waiting2;

  scan_addr_gen dut (
    .clk(clk), .rst(rst), .clr(clr), .step(step), .dir(dir), .line_ack(line_ack),
    .col(col), .row(row), .plane(plane), .col_last(col_last),
    .line_done(line_done), .frame_done(frame_done), .waiting(waiting)
  );

  scan_addr_gen #(.NUM_PANELS(2), .PANEL_COLS(32), .SCAN_ROWS(2), .PLANES(2)) dut2 (
    .clk(clk), .rst(rst2), .clr(clr2), .step(step2), .dir(dir2), .line_ack(ack2),
    .col(col2), .row(row2), .plane(plane2), .col_last(col_last2),
    .line_done(line_done2), .frame_done(frame_done2), .waiting(waiting2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // shift a full 32-column line on dut then acknowledge it
  task automatic dut_line();
    step = 1'b1;
    repeat (32) tick();
    step = 1'b0;
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; step = 1'b0; dir = 1'b0; line_ack = 1'b0;
    rst2 = 1'b0; clr2 = 1'b0; step2 = 1'b0; dir2 = 1'b0; ack2 = 1'b0;
    tick();
    rst = 1'b1; rst2 = 1'b1;

    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_plane", plane, 0);
    chk("rst_waiting", waiting, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_col_last", col_last, 0);

    // ascending line of 32 columns
    for (int i = 0; i < 32; i++) begin
      step = 1'b1;
      tick();
      if (i < 31) begin
        chk("asc_col", col, i + 1);
        chk("asc_col_last", col_last, (i == 30) ? 1 : 0);
        chk("asc_line_done", line_done, 0);
      end
    end
    chk("eol_line_done", line_done, 1);
    chk("eol_waiting", waiting, 1);
    chk("eol_col", col, 31);
    chk("eol_frame_done", frame_done, 0);
    tick();
    chk("eol_pulse_once", line_done, 0);
    repeat (4) tick();
    chk("wait_col_hold", col, 31);
    chk("wait_row_hold", row, 0);
    chk("wait_still", waiting, 1);

    // ack releases WAIT; a second ack in SHIFT is ignored
    step = 1'b0;
    line_ack = 1'b1;
    tick();
    chk("ack_row", row, 1);
    chk("ack_col", col, 0);
    chk("ack_waiting", waiting, 0);
    tick();
    chk("ack_shift_row", row, 1);
    chk("ack_shift_col", col, 0);
    chk("ack_shift_waiting", waiting, 0);
    line_ack = 1'b0;

    // reach row 3, col 17, then clr
    dut_line();
    dut_line();
    step = 1'b1;
    repeat (17) tick();
    step = 1'b0;
    chk("pre_clr_col", col, 17);
    chk("pre_clr_row", row, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_col", col, 0);
    chk("clr_row", row, 0);
    chk("clr_plane", plane, 0);
    chk("clr_waiting", waiting, 0);

    // clr together with the line-ending step: no done pulse
    step = 1'b1;
    repeat (31) tick();
    chk("clr_eol_col", col, 31);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    step = 1'b0;
    chk("clr_eol_line_done", line_done, 0);
    chk("clr_eol_waiting", waiting, 0);
    chk("clr_eol_col0", col, 0);

    // clr while in WAIT
    dut_line();
    step = 1'b1;
    repeat (32) tick();
    step = 1'b0;
    chk("wait2_waiting", waiting, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_wait_waiting", waiting, 0);
    chk("clr_wait_row", row, 0);
    chk("clr_wait_line_done", line_done, 0);

    // rst low concurrent with step
    step = 1'b1;
    repeat (3) tick();
    chk("pre_rst_col", col, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    step = 1'b0;
    chk("rst_step_col", col, 0);
    chk("rst_step_row", row, 0);
    chk("rst_step_waiting", waiting, 0);

    // dut2: four lines, frame_done only on the fourth
    for (int l = 0; l < 4; l++) begin
      step2 = 1'b1;
      repeat (64) tick();
      step2 = 1'b0;
      chk("f_line_done", line_done2, 1);
      chk("f_frame_done", frame_done2, (l == 3) ? 1 : 0);
      chk("f_col_end", col2, 63);
      dir2 = (l == 3) ? 1'b1 : 1'b0;
      ack2 = 1'b1;
      tick();
      ack2 = 1'b0;
      chk("f_row", row2, (l == 0 || l == 2) ? 1 : 0);
      chk("f_plane", plane2, (l == 1 || l == 2) ? 1 : 0);
      chk("f_frame_low", frame_done2, 0);
    end

    // dut2: descending line, dir toggled mid-line
    chk("desc_start_col", col2, 63);
    chk("desc_start_last", col_last2, 0);
    for (int i = 0; i < 64; i++) begin
      step2 = 1'b1;
      if (i == 20) dir2 = 1'b0;
      tick();
      if (i < 63) begin
        chk("desc_col", col2, 62 - i);
        chk("desc_col_last", col_last2, (i == 62) ? 1 : 0);
      end
    end
    step2 = 1'b0;
    chk("desc_line_done", line_done2, 1);
    chk("desc_col_end", col2, 0);
    chk("desc_frame_done", frame_done2, 0);
    chk("desc_waiting", waiting2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_addr_gen.md
Name: scan_addr_gen

Overview:
- Parametrised successor to the single-panel column counter for the LED matrix controller.
- Generates the column, scan-row and bit-plane addresses used to drive chained HUB75-style panels.
- Adds selectable scan direction, row and plane counting, and a line-latch handshake that stalls shifting until the display side acknowledges the line.
- Sits between the top-level display FSM (source of step and ack) and the frame-buffer read address path.

Parameters:
NUM_PANELS, 1, number of daisy-chained panels
PANEL_COLS, 32, columns per panel
SCAN_ROWS, 8, row addresses per panel (1/8 scan for a 32x16 panel)
PLANES, 8, bit-planes per frame (BCM depth)
Derived: MAXCOL = NUM_PANELS*PANEL_COLS-1; COL_W = max(1,$clog2(MAXCOL+1)); ROW_W = max(1,$clog2(SCAN_ROWS)); PL_W = max(1,$clog2(PLANES))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
clr  in  1  synchronous clear of all counters, active-high
step  in  1  advance one column (accepted only in SHIFT)
dir  in  1  0 = columns ascend, 1 = descend; sampled at line start
line_ack  in  1  display has latched/blanked the line; releases WAIT
col  out  COL_W  current column address
row  out  ROW_W  current scan row
plane  out  PL_W  current bit-plane
col_last  out  1  col is the final column for the current direction
line_done  out  1  one-cycle pulse: a line has fully shifted
frame_done  out  1  one-cycle pulse: last line of last plane has shifted
waiting  out  1  high in WAIT state

Behaviour:
- Two states: SHIFT, WAIT. All outputs are registered except col_last (combinational from col and the latched direction).
- Priority: rst low > clr > all other inputs.
- Reset (rst==0) and clr have identical effect:
  - state=SHIFT; row=0; plane=0; line_done=0; frame_done=0.
  - Direction latched from dir on that cycle; col=0 if dir=0, col=MAXCOL if dir=1.
- SHIFT, step=1, col_last=0: col increments (dir_l=0) or decrements (dir_l=1) by 1.
- SHIFT, step=1, col_last=1:
  - Next cycle: state=WAIT; line_done=1 for exactly one cycle; col holds its last value.
  - frame_done=1 in that same cycle if row==SCAN_ROWS-1 and plane==PLANES-1.
- SHIFT, step=0: hold.
- line_ack in SHIFT: ignored.
- WAIT: step ignored; col, row and plane hold.
- WAIT, line_ack=1 (next cycle):
  - state=SHIFT.
  - row advances; at SCAN_ROWS-1 it wraps to 0 and plane advances; at PLANES-1 plane wraps to 0.
  - dir re-sampled into the latched direction; col reloads to 0 or MAXCOL accordingly.
- Same-cycle step and line_ack in WAIT: ack taken, step dropped.
- dir changes mid-line: no effect until the next line start.
- Counters never exceed MAXCOL, SCAN_ROWS-1 or PLANES-1; there is no saturation mode, only wrap.
- col_last: (dir_l==0 && col==MAXCOL) || (dir_l==1 && col==0).
- Single-column config (MAXCOL=0): col_last is permanently 1, so every step ends a line.
- clr asserted in WAIT or mid-line: immediate return to line 0, plane 0, with no done pulses.

Test Plan:
- Reset, defaults, dir=0 -> col=0, row=0, plane=0, waiting=0, line_done=0, frame_done=0, col_last=0.
- 32 steps, dir=0 -> col counts 0..31; col_last=1 at col=31; after the 32nd step, line_done pulses once and waiting=1; 5 extra steps leave col=31.
- line_ack in WAIT -> row=1, col=0, waiting=0; ack asserted again while in SHIFT -> no change.
- SCAN_ROWS=2, PLANES=2: run 4 lines with acks -> frame_done pulses only on the 4th line_done; after that ack, row=0 and plane=0.
- dir=1 at line start, NUM_PANELS=2 -> col starts at 63 and counts down to 0 with col_last at 0; toggling dir mid-line has no effect.
- clr at col=17, row=3 -> next cycle col=0, row=0, plane=0, state SHIFT; rst low concurrent with step -> reset values win.
